// File: rtl/ifetch_unit_if.sv
// Fetch-side signal bundle: PC register hookup, I-memory request/response and decode handshake.
// master is the fetch unit's view; slave is the view of the surrounding PC/memory/decode logic.
interface ifetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] pc_now;
    logic            pc_reg_en;
    logic            redirect;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            inst_fault;

    modport master (
        input  pc_now, redirect, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        output pc_reg_en, imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc, inst_fault
    );

    modport slave (
        output pc_now, redirect, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        input  pc_reg_en, imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc, inst_fault
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: credit-limited in-order I-memory reads from pc_now, buffered for decode.
// Define IFETCH_MISALIGN_CHK_EN to turn misaligned fetch addresses into fault entries.
module ifetch_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic           clk,
    input logic           rst,
    ifetch_unit_if.master bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = FIFO_DEPTH[CW:0];

    logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];
    logic [XLEN-1:0] pend_pc   [FIFO_DEPTH];
    logic [AW-1:0]   fifo_wr_q, fifo_rd_q, pend_wr_q, pend_rd_q;
    logic [CW-1:0]   fifo_cnt_q, outstanding_q, drop_q;
    logic [CW:0]     in_use;
    logic            credit, blocked, fault_push, req_valid, fire;
    logic            rsp_keep, rsp_drop, push, pop, inst_valid;
    logic [XLEN-1:0] push_data, push_pc;

    // Credits cover both in-flight requests and buffered words, so a response always has a slot.
    assign in_use     = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
    assign credit     = in_use < DEPTH_W;
    assign req_valid  = rst & ~bus.redirect & credit & ~blocked;
    assign fire       = req_valid & bus.imem_req_ready;
    assign rsp_keep   = bus.imem_rsp_valid & (drop_q == '0);
    assign rsp_drop   = bus.imem_rsp_valid & (drop_q != '0);
    assign push       = rsp_keep | fault_push;
    assign inst_valid = fifo_cnt_q != '0;
    assign pop        = inst_valid & bus.inst_ready;
    assign push_data  = fault_push ? '0 : bus.imem_rsp_data;
    assign push_pc    = fault_push ? bus.pc_now : pend_pc[pend_rd_q];

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = bus.pc_now;
    assign bus.pc_reg_en      = fire | (rst & bus.redirect);
    assign bus.inst_valid     = inst_valid;
    assign bus.inst_data      = inst_valid ? fifo_data[fifo_rd_q] : '0;
    assign bus.inst_pc        = inst_valid ? fifo_pc[fifo_rd_q] : '0;

`ifdef IFETCH_MISALIGN_CHK_EN
    logic stall_q;
    logic misalign;
    logic fifo_flt [FIFO_DEPTH];

    assign misalign = bus.pc_now[1:0] != 2'b00;
    assign blocked  = misalign | stall_q;
    // Fault waits until every live request has returned so it lands in program order.
    assign fault_push = misalign & ~stall_q & credit & ~bus.redirect &
                        (outstanding_q == drop_q);
    assign bus.inst_fault = inst_valid & fifo_flt[fifo_rd_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= 1'b0;
        end else if (bus.redirect) begin
            stall_q <= 1'b0;
        end else if (fault_push) begin
            stall_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_flt[i] <= 1'b0;
            end
        end else if (push && !bus.redirect) begin
            fifo_flt[fifo_wr_q] <= fault_push;
        end
    end
`else
    assign blocked        = 1'b0;
    assign fault_push     = 1'b0;
    assign bus.inst_fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
        end else if (bus.redirect) begin
            // A same-cycle pop was already seen by decode; flushing the rest covers it.
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                fifo_data[fifo_wr_q] <= push_data;
                fifo_pc[fifo_wr_q]   <= push_pc;
                fifo_wr_q            <= fifo_wr_q + 1'b1;
            end
            if (pop) begin
                fifo_rd_q <= fifo_rd_q + 1'b1;
            end
            fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                pend_pc[i] <= '0;
            end
            pend_wr_q <= '0;
            pend_rd_q <= '0;
        end else if (bus.redirect) begin
            pend_wr_q <= '0;
            pend_rd_q <= '0;
        end else begin
            if (fire) begin
                pend_pc[pend_wr_q] <= bus.pc_now;
                pend_wr_q          <= pend_wr_q + 1'b1;
            end
            if (rsp_keep) begin
                pend_rd_q <= pend_rd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding_q <= '0;
            drop_q        <= '0;
        end else if (bus.redirect) begin
            // Whatever is still in flight after this cycle belongs to the squashed path.
            outstanding_q <= outstanding_q - CW'(bus.imem_rsp_valid);
            drop_q        <= outstanding_q - CW'(bus.imem_rsp_valid);
        end else begin
            outstanding_q <= outstanding_q + CW'(fire) - CW'(bus.imem_rsp_valid);
            drop_q        <= drop_q - CW'(rsp_drop);
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: PC register and 1-cycle in-order memory are modelled here;
// memory returns the bitwise inverse of the address so data and PC can be checked together.
module tb_ifetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_hold;
    logic [31:0] target;
    logic [31:0] mem_q[$];
    logic [31:0] pc0;
    int          fire_cnt;
    int          n_asserts = 0;
    int          n_fail = 0;
    bit          seen;

    ifetch_unit_if #(.XLEN(32)) bus ();

    ifetch_unit #(.XLEN(32), .FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.pc_now <= 32'h8000_0000;
        end else if (bus.pc_reg_en) begin
            bus.pc_now <= bus.redirect ? target : bus.pc_now + 32'd4;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q.delete();
            bus.imem_rsp_valid <= 1'b0;
            bus.imem_rsp_data  <= '0;
            fire_cnt           <= 0;
        end else begin
            bus.imem_rsp_valid <= 1'b0;
            if (!mem_hold && mem_q.size() > 0) begin
                bus.imem_rsp_valid <= 1'b1;
                bus.imem_rsp_data  <= ~mem_q[0];
                void'(mem_q.pop_front());
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                mem_q.push_back(bus.imem_addr);
                fire_cnt <= fire_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Call in the low clock phase; consumes exactly one instruction when inst_ready=1.
    task automatic expect_inst(input string tag, input logic [31:0] pc);
        bit got_one = 1'b0;
        for (int i = 0; i < 30 && !got_one; i++) begin
            #1;
            if (bus.inst_valid === 1'b1) begin
                got_one = 1'b1;
                check({tag, " pc"}, bus.inst_pc, pc);
                check({tag, " data"}, bus.inst_data, ~pc);
                check({tag, " fault"}, {31'b0, bus.inst_fault}, 32'd0);
            end
            @(negedge clk);
        end
        if (!got_one) check({tag, " valid"}, {31'b0, bus.inst_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        mem_hold = 1'b0;
        target = '0;
        bus.redirect = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready = 1'b1;

        // 1: reset values, then in-order streaming
        #2;
        check("rst inst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("rst req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        check("rst pc_reg_en", {31'b0, bus.pc_reg_en}, 32'd0);
        check("rst inst_data", bus.inst_data, 32'd0);
        check("rst inst_pc", bus.inst_pc, 32'd0);
        check("rst inst_fault", {31'b0, bus.inst_fault}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t1 req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        check("t1 addr0", bus.imem_addr, 32'h8000_0000);
        check("t1 pc_reg_en0", {31'b0, bus.pc_reg_en}, 32'd1);
        @(negedge clk);
        #1;
        check("t1 addr1", bus.imem_addr, 32'h8000_0004);
        check("t1 pc_reg_en1", {31'b0, bus.pc_reg_en}, 32'd1);
        expect_inst("t1 i0", 32'h8000_0000);
        expect_inst("t1 i1", 32'h8000_0004);
        expect_inst("t1 i2", 32'h8000_0008);
        expect_inst("t1 i3", 32'h8000_000C);

        // 2: decode back-pressure from a clean start
        rst = 1'b0;
        bus.inst_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("t2 hold pc a", bus.inst_pc, 32'h8000_0000);
        check("t2 hold data a", bus.inst_data, 32'h7FFF_FFFF);
        repeat (5) @(negedge clk);
        #1;
        check("t2 fires", fire_cnt, 32'd2);
        check("t2 req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        check("t2 inst_valid", {31'b0, bus.inst_valid}, 32'd1);
        check("t2 hold pc b", bus.inst_pc, 32'h8000_0000);
        check("t2 hold data b", bus.inst_data, 32'h7FFF_FFFF);
        check("t2 pc_now", bus.pc_now, 32'h8000_0008);
        bus.inst_ready = 1'b1;
        expect_inst("t2 i0", 32'h8000_0000);
        expect_inst("t2 i1", 32'h8000_0004);
        expect_inst("t2 i2", 32'h8000_0008);
        expect_inst("t2 i3", 32'h8000_000C);

        // 3: redirect with two requests in flight
        mem_hold = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("t3 credits out", {31'b0, bus.imem_req_valid}, 32'd0);
        check("t3 fifo empty", {31'b0, bus.inst_valid}, 32'd0);
        check("t3 in flight", mem_q.size(), 32'd2);
        bus.redirect = 1'b1;
        target = 32'h8000_0100;
        #1;
        check("t3 redir pc_reg_en", {31'b0, bus.pc_reg_en}, 32'd1);
        check("t3 redir req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        @(negedge clk);
        bus.redirect = 1'b0;
        mem_hold = 1'b0;
        #1;
        check("t3 post inst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("t3 post pc_now", bus.pc_now, 32'h8000_0100);
        expect_inst("t3 i0", 32'h8000_0100);
        expect_inst("t3 i1", 32'h8000_0104);

        // 4: memory not ready
        bus.imem_req_ready = 1'b0;
        bus.inst_ready = 1'b0;
        pc0 = bus.pc_now;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t4 pc_reg_en", {31'b0, bus.pc_reg_en}, 32'd0);
            check("t4 addr", bus.imem_addr, pc0);
            @(negedge clk);
        end
        check("t4 pc_now", bus.pc_now, pc0);
        bus.imem_req_ready = 1'b1;
        bus.inst_ready = 1'b1;
        expect_inst("t4 i0", 32'h8000_0108);
        expect_inst("t4 i1", 32'h8000_010C);
        expect_inst("t4 i2", 32'h8000_0110);

        // 5: asynchronous reset with two words buffered
        bus.inst_ready = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("t5 buffered", {31'b0, bus.inst_valid}, 32'd1);
        check("t5 head pc", bus.inst_pc, 32'h8000_0114);
        check("t5 head data", bus.inst_data, 32'h7FFF_FEEB);
        check("t5 full", {31'b0, bus.imem_req_valid}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("t5 inst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("t5 req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        check("t5 pc_reg_en", {31'b0, bus.pc_reg_en}, 32'd0);
        check("t5 inst_data", bus.inst_data, 32'd0);
        check("t5 inst_pc", bus.inst_pc, 32'd0);
        check("t5 inst_fault", {31'b0, bus.inst_fault}, 32'd0);
        @(negedge clk);
        bus.inst_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("t5 rel inst_valid", {31'b0, bus.inst_valid}, 32'd0);
        expect_inst("t5 i0", 32'h8000_0000);

        // 6: misaligned redirect target
        bus.redirect = 1'b1;
        target = 32'h8000_0002;
        @(negedge clk);
        bus.redirect = 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
        bus.inst_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            #1;
            if (bus.inst_valid === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        check("t6 valid", {31'b0, bus.inst_valid}, 32'd1);
        check("t6 fault", {31'b0, bus.inst_fault}, 32'd1);
        check("t6 pc", bus.inst_pc, 32'h8000_0002);
        check("t6 data", bus.inst_data, 32'd0);
        check("t6 req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        check("t6 pc_reg_en", {31'b0, bus.pc_reg_en}, 32'd0);
        repeat (3) @(negedge clk);
        check("t6 pc_now", bus.pc_now, 32'h8000_0002);
        bus.inst_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("t6 stall valid", {31'b0, bus.inst_valid}, 32'd0);
        check("t6 stall req", {31'b0, bus.imem_req_valid}, 32'd0);
        bus.redirect = 1'b1;
        target = 32'h8000_0200;
        @(negedge clk);
        bus.redirect = 1'b0;
        expect_inst("t6 resume", 32'h8000_0200);
`else
        expect_inst("t6 i0", 32'h8000_0002);
        expect_inst("t6 i1", 32'h8000_0006);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
